// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The ovf signal exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor; stage k resolves bits of slice k (WIDTH/STAGES wide).
// Define CLA_PIPE_OVF_EN to add the signed-overflow output ovf. STAGES must be at least 2.
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;
    localparam int unsigned RW = WIDTH - SW;

    // Returns {carry_out, sum}; group carries come from group G/P, ripple only inside a group.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] s;
        logic [NG:0]   gc;
        logic          gg;
        logic          gp;
        logic          c;
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int unsigned j = 0; j < NG; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int unsigned i = 0; i < GROUP; i++) begin
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp = gp & p[j*GROUP+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
            c = gc[j];
            for (int unsigned i = 0; i < GROUP; i++) begin
                s[j*GROUP+i] = p[j*GROUP+i] ^ c;
                c            = g[j*GROUP+i] | (p[j*GROUP+i] & c);
            end
        end
        return {gc[NG], s};
    endfunction

    logic [WIDTH-1:0]             b_eff;
    logic                         adv;
    logic [STAGES-1:0]            st_v;
    logic [STAGES-1:0]            st_c;
    logic [STAGES-1:0][WIDTH-1:0] st_s;
    logic [STAGES-2:0][RW-1:0]    st_ra;
    logic [STAGES-2:0][RW-1:0]    st_rb;
`ifdef CLA_PIPE_OVF_EN
    logic                         ovf_w;
`endif

    assign b_eff        = bus.b ^ {WIDTH{bus.sub}};
    // The whole pipe moves together; it only holds while the output beat is refused.
    assign adv          = !st_v[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    x;
        logic [SW-1:0]    y;
        logic             ci;
        logic             vin;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nxt;
        logic [SW:0]      res;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_head
            assign x    = bus.a[SW-1:0];
            assign y    = b_eff[SW-1:0];
            assign ci   = bus.sub | bus.cin;
            assign vin  = bus.in_valid;
            assign s_in = '0;
        end else begin : g_body
            assign x    = st_ra[k-1][SW-1:0];
            assign y    = st_rb[k-1][SW-1:0];
            assign ci   = st_c[k-1];
            assign vin  = st_v[k-1];
            assign s_in = st_s[k-1];
        end

        assign res = cla_slice(x, y, ci);

        always_comb begin
            s_nxt                = s_in;
            s_nxt[k*SW +: SW]    = res[SW-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vin;
                c_q <= res[SW];
                s_q <= s_nxt;
            end
        end

        assign st_v[k] = v_q;
        assign st_c[k] = c_q;
        assign st_s[k] = s_q;

        // Unconsumed operand bits, shifted so the next slice always sits at the bottom.
        if (k < STAGES - 1) begin : g_rem
            logic [RW-1:0] ra_d;
            logic [RW-1:0] rb_d;
            logic [RW-1:0] ra_q;
            logic [RW-1:0] rb_q;

            if (k == 0) begin : g_load
                assign ra_d = bus.a[WIDTH-1:SW];
                assign rb_d = b_eff[WIDTH-1:SW];
            end else begin : g_shift
                assign ra_d = st_ra[k-1] >> SW;
                assign rb_d = st_rb[k-1] >> SW;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end

            assign st_ra[k] = ra_q;
            assign st_rb[k] = rb_q;
        end

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
            assign ovf_d = res[SW] ^ (res[SW-1] ^ x[SW-1] ^ y[SW-1]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf_w = ovf_q;
        end
`endif
    end

    assign bus.out_valid = st_v[STAGES-1];
    assign bus.sum       = st_s[STAGES-1];
    assign bus.cout      = st_c[STAGES-1];
`ifdef CLA_PIPE_OVF_EN
    assign bus.ovf       = ovf_w;
`endif

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits; SHALL be a multiple of GROUP*STAGES.
REQ-002 Parameter GROUP, default 4, bits per carry-lookahead group (generate/propagate computed per group).
REQ-003 Parameter STAGES, default 2, pipeline stages; each stage SHALL resolve WIDTH/STAGES bits.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (add mode only).
REQ-011 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored).
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 cout  output  1  carry-out of MSB (in sub mode: 1 = no borrow).

Function
REQ-016 Per bit: g = a&b', p = a^b' (b' = b or ~b per sub); sum bit = p ^ carry_in; group carry-out = G | (P & group carry-in), using group-level G/P lookahead, not bit ripple across groups.
REQ-017 Stage k SHALL compute bits [k*W/S .. (k+1)*W/S-1] from the carry registered out of stage k-1; stage 0 uses cin (add) or 1 (sub).
REQ-018 Unconsumed operand slices and already-produced sum slices SHALL be carried forward in per-stage registers with a per-stage valid bit.
REQ-019 Latency: beat accepted at edge N SHALL appear on out_valid/sum/cout after edge N+STAGES-1 (i.e. visible in cycle N+STAGES) when not stalled; throughput one beat/cycle.
REQ-020 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-021 Stall: when out_valid && !out_ready, every stage register SHALL hold; in_ready = !out_valid || out_ready.
REQ-022 Bubbles (invalid stage slots) SHALL advance regardless of stall only if a downstream slot frees; no beat dropped, duplicated or reordered.
REQ-023 sum/cout SHALL remain stable while out_valid && !out_ready.
REQ-024 Widths: internal carry chain one bit beyond each slice; result truncated to WIDTH, overflow only via cout (and ovf when enabled).

Reset
REQ-025 With rst_n low at a rising edge, all stage valid bits SHALL clear; out_valid = 0, sum = 0, cout = 0 (ovf = 0) on the following cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; no partial result emitted after release.
REQ-027 in_ready SHALL be 1 during and immediately after reset (pipeline empty); inputs during reset ignored.

Configuration
REQ-028 Macro CLA_PIPE_OVF_EN defined: output ovf (1 bit, aligned with sum) = carry into MSB XOR carry out of MSB (signed two's-complement overflow).
REQ-029 Macro CLA_PIPE_OVF_EN undefined: ovf port and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=32, GROUP=4, STAGES=2)
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> two cycles later sum=0x00000000, cout=1 (ovf=0).
REQ-031 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1; a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0.
REQ-032 Back-to-back 100 random beats, out_ready=1 -> results in order, one per cycle, match a+b+cin / a-b reference, latency 2.
REQ-033 out_ready held 0 for 5 cycles with pipeline full -> in_ready=0, sum/cout frozen; on release beats drain in order, none lost.
REQ-034 rst_n low one cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat appears afterward; new beat after reset completes with latency 2.
REQ-035 Carry crossing stage boundary: a=0x0000FFFF, b=0x00000001 -> sum=0x00010000, cout=0.
